// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: h/v pixel counters with per-axis phase FSMs and a start/stop run FSM.
// Optional VGA_FRAME_COUNT_EN adds an 8-bit free-running frame counter output.
module vga_timing_controller #(
    parameter int H_ACTIVE        = 320,
    parameter int H_FRONT         = 8,
    parameter int H_SYNC          = 48,
    parameter int H_BACK          = 24,
    parameter int V_ACTIVE        = 240,
    parameter int V_FRONT         = 3,
    parameter int V_SYNC          = 4,
    parameter int V_BACK          = 15,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pixel_en,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_end,
    output logic       frame_end
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    // state  | meaning
    // IDLE   | raster halted, counters parked at 0, phases ACTIVE
    // RUN    | counters advance on each pixel_en tick
    // ACTIVE | (per axis) visible region
    // FRONT  | (per axis) front porch
    // SYNC   | (per axis) sync pulse
    // BACK   | (per axis) back porch

    localparam int CW      = 10;
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
        $error("vga_timing_controller: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_B_FRONT = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_B_SYNC  = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] H_B_BACK  = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_B_FRONT = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_B_SYNC  = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] V_B_BACK  = CW'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

    state_t          state_q, state_d;
    phase_t          h_phase_q, h_phase_d;
    phase_t          v_phase_q, v_phase_d;
    logic [CW-1:0]   h_count_q, h_count_d;
    logic [CW-1:0]   v_count_q, v_count_d;
    logic            stop_pending_q, stop_pending_d;

    logic [CW-1:0]   h_inc, v_inc;
    logic            h_wrap, v_wrap;
    logic            line_end_c, frame_end_c;

    // Phase moves when the post-increment count lands on a boundary; wrap always returns to ACTIVE.
    function automatic phase_t step_phase(input phase_t cur, input logic wrap,
                                          input logic [CW-1:0] inc,
                                          input logic [CW-1:0] b_front,
                                          input logic [CW-1:0] b_sync,
                                          input logic [CW-1:0] b_back);
        step_phase = cur;
        if (wrap)                step_phase = ACTIVE;
        else if (inc == b_front) step_phase = FRONT;
        else if (inc == b_sync)  step_phase = SYNC;
        else if (inc == b_back)  step_phase = BACK;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            h_phase_q      <= ACTIVE;
            v_phase_q      <= ACTIVE;
            h_count_q      <= '0;
            v_count_q      <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_phase_q      <= h_phase_d;
            v_phase_q      <= v_phase_d;
            h_count_q      <= h_count_d;
            v_count_q      <= v_count_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        h_phase_d      = h_phase_q;
        v_phase_d      = v_phase_q;
        h_count_d      = h_count_q;
        v_count_d      = v_count_q;
        stop_pending_d = stop_pending_q;

        h_inc       = h_count_q + 1'b1;
        v_inc       = v_count_q + 1'b1;
        h_wrap      = (h_count_q == H_LAST);
        v_wrap      = (v_count_q == V_LAST);
        line_end_c  = (state_q == RUN) && pixel_en && h_wrap;
        frame_end_c = line_end_c && v_wrap;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = RUN;
                    h_count_d      = '0;
                    v_count_d      = '0;
                    h_phase_d      = ACTIVE;
                    v_phase_d      = ACTIVE;
                    stop_pending_d = 1'b0;
                end
            end
            RUN: begin
                if (frame_end_c && (stop_pending_q || stop)) begin
                    state_d        = IDLE;
                    h_count_d      = '0;
                    v_count_d      = '0;
                    h_phase_d      = ACTIVE;
                    v_phase_d      = ACTIVE;
                    stop_pending_d = 1'b0;
                end else begin
                    if (stop) stop_pending_d = 1'b1;
                    if (pixel_en) begin
                        h_count_d = h_wrap ? '0 : h_inc;
                        h_phase_d = step_phase(h_phase_q, h_wrap, h_inc,
                                               H_B_FRONT, H_B_SYNC, H_B_BACK);
                        if (h_wrap) begin
                            v_count_d = v_wrap ? '0 : v_inc;
                            v_phase_d = step_phase(v_phase_q, v_wrap, v_inc,
                                                   V_B_FRONT, V_B_SYNC, V_B_BACK);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sync/video decode uses registered state only, so pins cannot glitch on input changes.
    assign busy      = (state_q == RUN);
    assign hsync     = (h_phase_q == SYNC) ^ SYNC_ACTIVE_LOW;
    assign vsync     = (v_phase_q == SYNC) ^ SYNC_ACTIVE_LOW;
    assign video_on  = (state_q == RUN) && (h_phase_q == ACTIVE) && (v_phase_q == ACTIVE);
    assign pixel_x   = h_count_q;
    assign pixel_y   = v_count_q;
    assign line_end  = line_end_c;
    assign frame_end = frame_end_c;

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count_q, frame_count_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_count_q <= '0;
        else          frame_count_q <= frame_count_d;
    end

    always_comb begin
        frame_count_d = frame_count_q;
        if (frame_end_c) frame_count_d = frame_count_q + 1'b1;
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller using a shrunken raster (15 x 8 ticks per frame).
// Exercises frame_count as well when built with VGA_FRAME_COUNT_EN.
module tb_vga_timing_controller;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic       clk = 1'b0;
    logic       reset_n, pixel_en, start, stop;
    logic       busy, hsync, vsync, video_on, line_end, frame_end;
    logic [9:0] pixel_x, pixel_y;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count;
`endif

    vga_timing_controller #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pixel_en(pixel_en), .start(start), .stop(stop),
        .busy(busy), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .line_end(line_end), .frame_end(frame_end)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference raster model: run flag, x/y position, pending stop, frame counter.
    bit       mrun, mpend;
    int       mx, my;
    bit [7:0] mfc;
    logic     last_le, last_fe, last_von, last_hs, last_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mrun = 0; mpend = 0; mx = 0; my = 0; mfc = '0;
    endtask

    // One clock: drive inputs, compare every output mid-cycle, then advance the model.
    task automatic cyc(input logic pe, input logic st, input logic sp);
        logic        e_le, e_fe, e_hs, e_vs, e_von;
        logic [25:0] e_vec;
        pixel_en = pe; start = st; stop = sp;
        @(negedge clk);
        e_le  = mrun && pe && (mx == HT - 1);
        e_fe  = e_le && (my == VT - 1);
        e_hs  = !(mx >= HA + HF && mx < HA + HF + HS);
        e_vs  = !(my >= VA + VF && my < VA + VF + VS);
        e_von = mrun && (mx < HA) && (my < VA);
        e_vec = {mrun, e_hs, e_vs, e_von, e_le, e_fe, 10'(mx), 10'(my)};
        chk("outs", {6'b0, busy, hsync, vsync, video_on, line_end, frame_end, pixel_x, pixel_y},
            {6'b0, e_vec});
`ifdef VGA_FRAME_COUNT_EN
        chk("frame_count", {24'b0, frame_count}, {24'b0, mfc});
`endif
        last_le = line_end; last_fe = frame_end; last_von = video_on;
        last_hs = hsync; last_busy = busy;
        @(posedge clk);
        #1;
        if (!mrun) begin
            if (st) begin mrun = 1; mx = 0; my = 0; mpend = 0; end
        end else begin
            if (e_fe) mfc = mfc + 8'd1;
            if (e_fe && (mpend || sp)) begin
                mrun = 0; mx = 0; my = 0; mpend = 0;
            end else begin
                if (sp) mpend = 1;
                if (pe) begin
                    if (mx == HT - 1) begin
                        mx = 0;
                        my = (my == VT - 1) ? 0 : my + 1;
                    end else begin
                        mx = mx + 1;
                    end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int le1, le2, fe1, von, hsl, le_pe0, fe_at;
        reset_n = 1'b0; pixel_en = 1'b0; start = 1'b0; stop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        pixel_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_hsync", {31'b0, hsync}, 1);
        chk("rst_vsync", {31'b0, vsync}, 1);
        chk("rst_video_on", {31'b0, video_on}, 0);
        chk("rst_line_end", {31'b0, line_end}, 0);
        chk("rst_frame_end", {31'b0, frame_end}, 0);
        chk("rst_pixel_x", {22'b0, pixel_x}, 0);
        chk("rst_pixel_y", {22'b0, pixel_y}, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // stop ignored in IDLE; start wins over a simultaneous stop
        cyc(1, 0, 1);
        cyc(0, 1, 1);
        chk("start_busy", {31'b0, busy}, 1);
        chk("start_x", {22'b0, pixel_x}, 0);

        // Continuous pixel_en: strobe timing, hsync width, visible area
        le1 = -1; le2 = -1; fe1 = -1; von = 0; hsl = 0;
        for (int i = 0; i < 135; i++) begin
            cyc(1, (i == 50), 0);
            if (last_le && le1 >= 0 && le2 < 0) le2 = i;
            if (last_le && le1 < 0) le1 = i;
            if (last_fe && fe1 < 0) fe1 = i;
            if (i < 120) von += int'(last_von);
            if (i < 15) hsl += int'(!last_hs);
        end
        chk("first_line_end", le1, 14);
        chk("second_line_end", le2, 29);
        chk("first_frame_end", fe1, 119);
        chk("video_on_per_frame", von, 32);
        chk("hsync_low_ticks", hsl, 3);

        // Alternating pixel_en doubles every period; no strobe on idle ticks
        le1 = -1; le2 = -1; le_pe0 = 0;
        for (int i = 0; i < 60; i++) begin
            cyc((i % 2) == 0, 0, 0);
            if (last_le && (i % 2) == 1) le_pe0++;
            if (last_le && le1 >= 0 && le2 < 0) le2 = i;
            if (last_le && le1 < 0) le1 = i;
        end
        chk("half_rate_le1", le1, 28);
        chk("half_rate_le2", le2, 58);
        chk("no_strobe_pe0", le_pe0, 0);

        // Stop mid-frame (y=3): frame completes, then idle at 0/0
        chk("pre_stop_y", {22'b0, pixel_y}, 3);
        cyc(1, 0, 1);
        fe_at = -1;
        for (int i = 0; i < 400 && fe_at < 0; i++) begin
            cyc(1, 0, 0);
            if (last_fe) fe_at = i;
        end
        chk("stop_fe_at", fe_at, 73);
        chk("busy_at_fe", {31'b0, last_busy}, 1);
        chk("stop_busy", {31'b0, busy}, 0);
        chk("stop_x", {22'b0, pixel_x}, 0);
        chk("stop_y", {22'b0, pixel_y}, 0);
        repeat (3) cyc(1, 0, 0);

        // Restart and go to x=5,y=2
        cyc(1, 1, 0);
        repeat (35) cyc(1, 0, 0);
        chk("pre_rst_x", {22'b0, pixel_x}, 5);
        chk("pre_rst_y", {22'b0, pixel_y}, 2);

        // Async reset mid-frame with start held throughout
        start = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_x", {22'b0, pixel_x}, 0);
        chk("arst_y", {22'b0, pixel_y}, 0);
        chk("arst_hsync", {31'b0, hsync}, 1);
        chk("arst_video_on", {31'b0, video_on}, 0);
        chk("arst_line_end", {31'b0, line_end}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_busy", {31'b0, busy}, 0);
        reset_n = 1'b1;
        cyc(1, 1, 0);
        chk("post_rst_busy", {31'b0, busy}, 1);
        chk("post_rst_x", {22'b0, pixel_x}, 0);
        repeat (20) cyc(1, 0, 0);

`ifdef VGA_FRAME_COUNT_EN
        // 257 frames since reset with a stop/start in between: counter wraps to 1
        begin
            int nfe;
            nfe = 0;
            for (int i = 0; i < 257 * VT * HT + 400 && nfe < 257; i++) begin
                cyc(1, !mrun, (i == 1000));
                if (last_fe) nfe++;
            end
            chk("frames_seen", nfe, 257);
            chk("frame_count_wrap", {24'b0, frame_count}, 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
